// File: rtl/tx_sbinit_multilane.sv
// Transmit-side SBINIT sequencer for the sideband: requests the clock pattern,
// retries a bounded number of times, picks one functional lane out of the
// redundant set, then exchanges Out-of-Reset and done_req/done_resp under a
// global timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | block disabled, counters and outputs held at zero
// S_PATTERN  | pattern burst outstanding, waiting for i_start_pattern_done
// S_OOR      | lane chosen, sending own OOR and waiting for partner OOR
// S_DONE_REQ | done_req sent, waiting for partner done_resp
// S_END      | SBINIT complete, outputs frozen
// S_ERROR    | timeout or pattern exhaustion, outputs frozen
module tx_sbinit_multilane #(
  parameter int SB_MSG_WIDTH     = 4,
  parameter int N_LANES          = 2,
  parameter int MAX_PATTERN_ITER = 4,
  parameter int TIMEOUT_CYCLES   = 8000,
  parameter logic [SB_MSG_WIDTH-1:0] MSG_OOR       = SB_MSG_WIDTH'(3),
  parameter logic [SB_MSG_WIDTH-1:0] MSG_DONE_REQ  = SB_MSG_WIDTH'(1),
  parameter logic [SB_MSG_WIDTH-1:0] MSG_DONE_RESP = SB_MSG_WIDTH'(2)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_SBINIT_en,
  input  logic                    i_start_pattern_done,
  input  logic [N_LANES-1:0]      i_pattern_detected,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_start_pattern_req,
  output logic [N_LANES-1:0]      o_lane_sel,
  output logic                    o_valid_tx,
  output logic                    o_SBINIT_end_tx,
  output logic                    o_timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    ITER_MAX = 4'(MAX_PATTERN_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_PATTERN, S_OOR, S_DONE_REQ, S_END, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              iter_q, iter_d, iter_inc;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [SB_MSG_WIDTH-1:0] msg_d;
  logic                    req_d, valid_d, end_d, err_d, timed;
  logic [N_LANES-1:0]      lane_d, lane_first;

  // Lowest-index detected lane as a one-hot vector.
  always_comb begin
    lane_first = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (i_pattern_detected[i]) begin
        lane_first    = '0;
        lane_first[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; enable-low is applied last so it wins.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    tmo_d    = tmo_q;
    msg_d    = o_encoded_SB_msg_tx;
    req_d    = 1'b0;
    lane_d   = o_lane_sel;
    valid_d  = o_valid_tx;
    end_d    = o_SBINIT_end_tx;
    err_d    = o_timeout_err;
    timed    = 1'b0;
    iter_inc = iter_q + 4'd1;

    if (i_falling_edge_busy && !i_rx_valid) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        iter_d  = '0;
        tmo_d   = '0;
        msg_d   = '0;
        lane_d  = '0;
        valid_d = 1'b0;
        end_d   = 1'b0;
        err_d   = 1'b0;
        if (i_SBINIT_en) begin
          state_d = S_PATTERN;
          req_d   = 1'b1;
        end
      end
      S_PATTERN: begin
        timed = 1'b1;
        if (i_start_pattern_done) begin
          if (|i_pattern_detected) begin
            lane_d  = lane_first;
            msg_d   = MSG_OOR;
            valid_d = 1'b1;
            state_d = S_OOR;
          end else begin
            iter_d = iter_inc;
            if (iter_inc == ITER_MAX) state_d = S_ERROR;
            else                      req_d   = 1'b1;
          end
        end
      end
      S_OOR: begin
        timed = 1'b1;
        if (i_decoded_SB_msg == MSG_OOR && !o_valid_tx) begin
          msg_d   = MSG_DONE_REQ;
          valid_d = 1'b1;
          state_d = S_DONE_REQ;
        end
      end
      S_DONE_REQ: begin
        timed = 1'b1;
        if (i_decoded_SB_msg == MSG_DONE_RESP) begin
          end_d   = 1'b1;
          state_d = S_END;
        end
      end
      S_END:   ;
      S_ERROR: ;
      default: state_d = S_IDLE;
    endcase

    if (timed) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST && state_d != S_END) state_d = S_ERROR;
    end

    if (state_d == S_ERROR) begin
      err_d   = 1'b1;
      valid_d = 1'b0;
      req_d   = 1'b0;
    end

    if (!i_SBINIT_en) begin
      state_d = S_IDLE;
      iter_d  = '0;
      tmo_d   = '0;
      msg_d   = '0;
      req_d   = 1'b0;
      lane_d  = '0;
      valid_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q             <= S_IDLE;
      iter_q              <= '0;
      tmo_q               <= '0;
      o_encoded_SB_msg_tx <= '0;
      o_start_pattern_req <= 1'b0;
      o_lane_sel          <= '0;
      o_valid_tx          <= 1'b0;
      o_SBINIT_end_tx     <= 1'b0;
      o_timeout_err       <= 1'b0;
    end else begin
      state_q             <= state_d;
      iter_q              <= iter_d;
      tmo_q               <= tmo_d;
      o_encoded_SB_msg_tx <= msg_d;
      o_start_pattern_req <= req_d;
      o_lane_sel          <= lane_d;
      o_valid_tx          <= valid_d;
      o_SBINIT_end_tx     <= end_d;
      o_timeout_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_tx_sbinit_multilane.sv
// Scoreboard bench for tx_sbinit_multilane. Stimulus tasks describe the
// handshake at message level and push the expected output bundle together
// with the cycle it must appear on; a monitor pops an entry each time the
// DUT outputs change.
module tb_tx_sbinit_multilane;

  localparam int MAXI = 3;
  localparam int TMO  = 50;
  localparam logic [3:0] M_OOR  = 4'd3;
  localparam logic [3:0] M_REQ  = 4'd1;
  localparam logic [3:0] M_RESP = 4'd2;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_SBINIT_en = 1'b0;
  logic       i_start_pattern_done = 1'b0;
  logic [1:0] i_pattern_detected = '0;
  logic       i_falling_edge_busy = 1'b0;
  logic       i_rx_valid = 1'b0;
  logic [3:0] i_decoded_SB_msg = '0;
  logic [3:0] o_encoded_SB_msg_tx;
  logic       o_start_pattern_req;
  logic [1:0] o_lane_sel;
  logic       o_valid_tx;
  logic       o_SBINIT_end_tx;
  logic       o_timeout_err;

  tx_sbinit_multilane #(
    .SB_MSG_WIDTH(4), .N_LANES(2), .MAX_PATTERN_ITER(MAXI), .TIMEOUT_CYCLES(TMO),
    .MSG_OOR(M_OOR), .MSG_DONE_REQ(M_REQ), .MSG_DONE_RESP(M_RESP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_SBINIT_en(i_SBINIT_en),
    .i_start_pattern_done(i_start_pattern_done), .i_pattern_detected(i_pattern_detected),
    .i_falling_edge_busy(i_falling_edge_busy), .i_rx_valid(i_rx_valid),
    .i_decoded_SB_msg(i_decoded_SB_msg), .o_encoded_SB_msg_tx(o_encoded_SB_msg_tx),
    .o_start_pattern_req(o_start_pattern_req), .o_lane_sel(o_lane_sel),
    .o_valid_tx(o_valid_tx), .o_SBINIT_end_tx(o_SBINIT_end_tx), .o_timeout_err(o_timeout_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] msg;
    logic       req;
    logic [1:0] lane;
    logic       valid;
    logic       endt;
    logic       err;
  } obs_t;

  typedef struct {
    int   c;
    obs_t o;
  } exp_t;

  exp_t q[$];
  obs_t e = '0;
  obs_t last = '0;
  obs_t dut_obs;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   iters = 0;
  bit   rst_chk = 1'b0;
  bit   stim_done = 1'b0;

  assign dut_obs = {o_encoded_SB_msg_tx, o_start_pattern_req, o_lane_sel,
                    o_valid_tx, o_SBINIT_end_tx, o_timeout_err};

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: compares every output change against the head of the queue.
  initial begin : monitor
    obs_t prev;
    exp_t x;
    bit   armed;
    prev  = '0;
    armed = 1'b0;
    forever begin
      @(negedge i_clk);
      if (rst_chk && !armed) begin
        checks++;
        if (dut_obs !== '0) begin
          errors++;
          $display("FAIL reset_state got obs=%h want obs=000", dut_obs);
        end
        armed = 1'b1;
        prev  = '0;
      end else if (armed && dut_obs !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_change got cyc=%0d obs=%h want no change", cyc, dut_obs);
        end else begin
          x = q.pop_front();
          if (x.c != cyc || x.o !== dut_obs) begin
            errors++;
            $display("FAIL out_change got cyc=%0d obs=%h want cyc=%0d obs=%h",
                     cyc, dut_obs, x.c, x.o);
          end
        end
        prev = dut_obs;
      end
      if (stim_done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL pending_change got none want cyc=%0d obs=%h", q[0].c, q[0].o);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got cyc=%0d want end of stimulus", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge i_clk);
    i_start_pattern_done = 1'b0;
    i_pattern_detected   = 2'($urandom);
    i_falling_edge_busy  = 1'b0;
    i_rx_valid           = 1'($urandom);
    i_decoded_SB_msg     = 4'd0;
  endtask

  task automatic wait_n(int n);
    repeat (n) tick();
  endtask

  task automatic commit(int c);
    if (e !== last) begin
      q.push_back('{c, e});
      last = e;
    end
  endtask

  task automatic enter(output int c0);
    c0 = cyc;
    iters = 0;
    i_SBINIT_en = 1'b1;
    e.req = 1'b1; commit(c0 + 1); tick();
    e.req = 1'b0; commit(c0 + 2); tick();
  endtask

  task automatic burst_fail();
    int c;
    c = cyc;
    i_start_pattern_done = 1'b1;
    i_pattern_detected   = 2'b00;
    iters++;
    if (iters >= MAXI) begin
      e.err = 1'b1; e.valid = 1'b0; commit(c + 1); tick();
    end else begin
      e.req = 1'b1; commit(c + 1); tick();
      e.req = 1'b0; commit(c + 2); tick();
    end
  endtask

  task automatic burst_pass(logic [1:0] d);
    int c;
    c = cyc;
    i_start_pattern_done = 1'b1;
    i_pattern_detected   = d;
    e.lane  = d & (~d + 2'd1);
    e.msg   = M_OOR;
    e.valid = 1'b1;
    commit(c + 1); tick();
  endtask

  task automatic clear_valid();
    int c;
    c = cyc;
    i_falling_edge_busy = 1'b1;
    i_rx_valid          = 1'b0;
    e.valid = 1'b0; commit(c + 1); tick();
  endtask

  task automatic busy_held();
    i_falling_edge_busy = 1'b1;
    i_rx_valid          = 1'b1;
    tick();
  endtask

  task automatic partner_oor_blocked();
    i_decoded_SB_msg = M_OOR;
    tick();
  endtask

  task automatic partner_oor_ok();
    int c;
    c = cyc;
    i_decoded_SB_msg = M_OOR;
    e.msg = M_REQ; e.valid = 1'b1; commit(c + 1); tick();
  endtask

  task automatic partner_resp();
    int c;
    c = cyc;
    i_decoded_SB_msg = M_RESP;
    e.endt = 1'b1; commit(c + 1); tick();
  endtask

  task automatic drop_en();
    int c;
    c = cyc;
    i_SBINIT_en = 1'b0;
    e = '0; commit(c + 1); tick();
    tick();
  endtask

  task automatic nominal(logic [1:0] d, int nfail, bit hold);
    int c0;
    enter(c0);
    repeat (nfail) begin
      burst_fail();
      wait_n($urandom_range(0, 2));
    end
    wait_n($urandom_range(0, 2));
    burst_pass(d);
    if (hold) begin
      partner_oor_blocked();
      busy_held();
      clear_valid();
      partner_oor_ok();
    end else begin
      wait_n($urandom_range(0, 2));
      clear_valid();
      wait_n($urandom_range(0, 2));
      partner_oor_ok();
    end
    wait_n($urandom_range(0, 2));
    clear_valid();
    wait_n($urandom_range(0, 2));
    partner_resp();
    wait_n(60);
    drop_en();
  endtask

  task automatic exhaust();
    int c0;
    enter(c0);
    repeat (MAXI) begin
      burst_fail();
      wait_n($urandom_range(0, 2));
    end
    wait_n(5);
    drop_en();
  endtask

  task automatic timeout_run(int mode, logic [1:0] d, int nfail);
    int c0;
    enter(c0);
    if (mode == 0) begin
      repeat (nfail) burst_fail();
    end else begin
      burst_pass(d);
      if (mode == 1) begin
        if ($urandom_range(0, 1) == 1) clear_valid();
        else                           partner_oor_blocked();
      end else begin
        clear_valid();
        partner_oor_ok();
      end
    end
    while (cyc < c0 + TMO) tick();
    e.err = 1'b1; e.valid = 1'b0; commit(c0 + TMO + 1); tick();
    wait_n(4);
    drop_en();
  endtask

  task automatic abort_run(logic [1:0] d);
    int c0;
    enter(c0);
    burst_pass(d);
    clear_valid();
    partner_oor_ok();
    wait_n($urandom_range(0, 3));
    drop_en();
  endtask

  task automatic reset_restart();
    int c0, c1;
    enter(c0);
    burst_fail();
    while (cyc < c0 + 30) tick();
    i_rst_n = 1'b0; i_SBINIT_en = 1'b0;
    e = '0; commit(cyc + 1); tick();
    i_rst_n = 1'b1; tick();
    enter(c1);
    repeat (MAXI - 1) begin
      burst_fail();
      wait_n($urandom_range(0, 1));
    end
    while (cyc < c1 + TMO) tick();
    e.err = 1'b1; e.valid = 1'b0; commit(c1 + TMO + 1); tick();
    wait_n(3);
    drop_en();
  endtask

  task automatic reset_in_oor(logic [1:0] d);
    int c0;
    enter(c0);
    burst_pass(d);
    wait_n($urandom_range(0, 2));
    i_rst_n = 1'b0; i_SBINIT_en = 1'b0;
    e = '0; commit(cyc + 1); tick();
    i_rst_n = 1'b1; tick();
  endtask

  initial begin : stim
    i_rst_n = 1'b0;
    i_SBINIT_en = 1'b0;
    wait_n(3);
    rst_chk = 1'b1;
    wait_n(2);
    i_rst_n = 1'b1;
    tick();

    nominal(2'b10, 0, 1'b1);
    nominal(2'b11, 2, 1'b0);
    exhaust();
    timeout_run(1, 2'b01, 0);
    timeout_run(0, 2'b01, 1);
    abort_run(2'b10);
    reset_restart();
    reset_in_oor(2'b11);

    repeat (12) begin
      case ($urandom_range(0, 4))
        0: nominal(2'($urandom_range(1, 3)), $urandom_range(0, MAXI - 1), 1'($urandom));
        1: exhaust();
        2: timeout_run($urandom_range(0, 2), 2'($urandom_range(1, 3)), $urandom_range(0, MAXI - 1));
        3: abort_run(2'($urandom_range(1, 3)));
        default: reset_in_oor(2'($urandom_range(1, 3)));
      endcase
    end

    wait_n(4);
    stim_done = 1'b1;
    wait_n(5);
  end

endmodule
